// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: sends one 11-bit frame (start, 8 data bits LSB-first, odd parity, stop) per accepted byte.
// Optional macro PS2_TX_BREAK_EN adds tx_break_i, which sends an 0xF0 break prefix frame ahead of the data frame.
`timescale 1ns/1ps
module ps2_keyboard_tx #(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       ck_i,
    input  logic       rst_ni,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
`ifdef PS2_TX_BREAK_EN
    input  logic       tx_break_i,
`endif
    output logic       tx_ready_o,
    input  logic       ps2c_in_i,
    output logic       ps2c_o,
    output logic       ps2d_o
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        GAP,
        WAIT_INH
    } state_e;

    state_e        state_q;
    logic [7:0]    shreg_q;
    logic [3:0]    bit_q;
    logic [CW-1:0] cnt_q;
    logic          sync_q;
    logic          inh_s_q;
    logic          ps2c_q;
    logic          ps2d_q;
    logic          pend_q;
`ifdef PS2_TX_BREAK_EN
    logic [7:0]    data_q;
    logic          brk_q;
`endif

    logic [3:0] bit_d;
    logic       next_d;

    function automatic logic frame_bit(input logic [3:0] n, input logic [7:0] sh);
        logic [2:0] idx;
        idx = 3'(n - 4'd1);
        case (n)
            4'd0:    frame_bit = 1'b0;
            4'd9:    frame_bit = ~^sh;
            4'd10:   frame_bit = 1'b1;
            default: frame_bit = sh[idx];
        endcase
    endfunction

    assign bit_d      = bit_q + 4'd1;
    assign next_d     = frame_bit(bit_d, shreg_q);
    assign tx_ready_o = (state_q == IDLE) && inh_s_q;
    assign ps2c_o     = ps2c_q;
    assign ps2d_o     = ps2d_q;

    // pend_q marks a frame still owed in shreg_q (abort retry or post-break data) to start after GAP.
    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shreg_q <= 8'd0;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
            sync_q  <= 1'b0;
            inh_s_q <= 1'b0;
            ps2c_q  <= 1'b1;
            ps2d_q  <= 1'b1;
            pend_q  <= 1'b0;
`ifdef PS2_TX_BREAK_EN
            data_q  <= 8'd0;
            brk_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= ps2c_in_i;
            inh_s_q <= sync_q;
            case (state_q)
                IDLE: begin
                    if (tx_valid_i && tx_ready_o) begin
`ifdef PS2_TX_BREAK_EN
                        shreg_q <= tx_break_i ? 8'hF0 : tx_data_i;
                        data_q  <= tx_data_i;
                        brk_q   <= tx_break_i;
`else
                        shreg_q <= tx_data_i;
`endif
                        state_q <= HI;
                        bit_q   <= 4'd0;
                        cnt_q   <= '0;
                        ps2c_q  <= 1'b1;
                        ps2d_q  <= 1'b0;
                    end
                end
                HI: begin
                    if (!inh_s_q && (bit_q != LAST_BIT)) begin
                        state_q <= WAIT_INH;
                        cnt_q   <= '0;
                        ps2c_q  <= 1'b1;
                        ps2d_q  <= 1'b1;
                        pend_q  <= 1'b1;
                    end else if (cnt_q == HALF_LAST) begin
                        state_q <= LO;
                        cnt_q   <= '0;
                        ps2c_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q  <= '0;
                        ps2c_q <= 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_q <= GAP;
                            ps2d_q  <= 1'b1;
`ifdef PS2_TX_BREAK_EN
                            if (brk_q) begin
                                shreg_q <= data_q;
                                brk_q   <= 1'b0;
                                pend_q  <= 1'b1;
                            end
`endif
                        end else begin
                            state_q <= HI;
                            bit_q   <= bit_d;
                            ps2d_q  <= next_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_INH: begin
                    if (inh_s_q) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (pend_q) begin
                            state_q <= HI;
                            bit_q   <= 4'd0;
                            ps2c_q  <= 1'b1;
                            ps2d_q  <= 1'b0;
                            pend_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ps2c_q  <= 1'b1;
                    ps2d_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Scoreboard bench for ps2_keyboard_tx: a host-side monitor decodes frames at PS2C falls and compares them with queued model frames.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;

    localparam int CD = 4;
    localparam int GP = 8;
    localparam int FRAME_LEN = 22 * CD;

    logic       ck = 1'b0;
    logic       rst_n = 1'b0;
    logic       txValid = 1'b0;
    logic [7:0] txData = 8'd0;
`ifdef PS2_TX_BREAK_EN
    logic       txBreak = 1'b0;
`endif
    logic       txReady;
    logic       ps2cIn = 1'b1;
    logic       ps2c;
    logic       ps2d;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int acceptEdge = 0;
    bit expectFirst = 1'b0;
    logic [10:0] expQ[$];

    ps2_keyboard_tx #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
        .ck_i       (ck),
        .rst_ni     (rst_n),
        .tx_valid_i (txValid),
        .tx_data_i  (txData),
`ifdef PS2_TX_BREAK_EN
        .tx_break_i (txBreak),
`endif
        .tx_ready_o (txReady),
        .ps2c_in_i  (ps2cIn),
        .ps2c_o     (ps2c),
        .ps2d_o     (ps2d)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    // Host's view of a byte: start 0, data LSB first, parity making the ones count odd, stop 1.
    function automatic logic [10:0] modelFrame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Host-side monitor: samples PS2D at each PS2C fall and drops partial frames after a long high stretch.
    int nBits = 0;
    int lastFall = 0;
    int highStreak = 0;
    int checkedAccept = -1;
    logic prevC = 1'b1;
    logic lowD = 1'b1;
    logic [10:0] rx = '0;
    always @(negedge ck) begin
        if (!rst_n) begin
            nBits = 0;
            highStreak = 0;
            prevC = 1'b1;
        end else begin
            if (ps2c === 1'b0) begin
                highStreak = 0;
                checkOutput("readyLowInFrame", 32'(txReady), 32'(0));
                if (prevC === 1'b1) begin
                    if (nBits > 0)
                        checkOutput("fallSpacing", 32'(cyc - lastFall), 32'(2 * CD));
                    else if (expectFirst && checkedAccept != acceptEdge) begin
                        checkOutput("firstFallLatency", 32'(cyc - acceptEdge), 32'(CD));
                        checkedAccept = acceptEdge;
                    end
                    lastFall = cyc;
                    rx[nBits[3:0]] = ps2d;
                    lowD = ps2d;
                    nBits++;
                    if (nBits == 11) begin
                        checks++;
                        if (expQ.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL unexpectedFrame: got %03h, expected no frame", rx);
                        end else begin
                            logic [10:0] e;
                            e = expQ.pop_front();
                            checks--;
                            checkOutput("frame", 32'(rx), 32'(e));
                        end
                        nBits = 0;
                    end
                end else begin
                    checkOutput("dataStableLow", 32'(ps2d), 32'(lowD));
                end
            end else begin
                highStreak++;
                if (highStreak > CD + 1 && nBits != 0) nBits = 0;
            end
            prevC = ps2c;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input bit brk, input bit clean,
                                 output int acc, output bit ok);
        @(negedge ck);
        txValid = 1'b1;
        txData = d;
`ifdef PS2_TX_BREAK_EN
        txBreak = brk;
`endif
        ok = 1'b0;
        acc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (txReady) begin
                if (brk) expQ.push_back(modelFrame(8'hF0));
                expQ.push_back(modelFrame(d));
                acc = cyc + 1;
                acceptEdge = acc;
                expectFirst = clean;
                ok = 1'b1;
                break;
            end
            @(negedge ck);
        end
        @(negedge ck);
        txValid = 1'b0;
        if (!ok) checkOutput("acceptTimeout", 32'(0), 32'(1));
    endtask

    task automatic waitReady(output int rc, output bit ok);
        ok = 1'b0;
        rc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge ck);
            if (txReady) begin
                rc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("readyTimeout", 32'(0), 32'(1));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int rc;
        int cnt;
        bit ok;
        bit ok2;
        bit seen;
        bit released;
        logic [7:0] dirBytes[5];
        logic [10:0] f16;

        dirBytes = '{8'h16, 8'h69, 8'h00, 8'hFF, 8'h01};
        f16 = modelFrame(8'h16);
        $display("[TB] ps2_keyboard_tx bench, CLK_DIV=%0d GAP=%0d", CD, GP);

        repeat (3) @(negedge ck);
        checkOutput("resetLines", 32'({ps2c, ps2d}), 32'(2'b11));
        rst_n = 1'b1;
        repeat (3) @(negedge ck);
        checkOutput("readyAfterReset", 32'(txReady), 32'(1));

        foreach (dirBytes[i]) begin
            applyStimulus(dirBytes[i], 1'b0, 1'b1, acc, ok);
            if (ok) begin
                waitReady(rc, ok2);
                if (ok2) checkOutput("readyReturn", 32'(rc - acc), 32'(FRAME_LEN + GP));
            end
        end
        checkOutput("directedDrained", 32'(expQ.size()), 32'(0));

        // Host holds the clock low before a byte is offered.
        ps2cIn = 1'b0;
        repeat (4) @(negedge ck);
        txValid = 1'b1;
        txData = 8'h16;
`ifdef PS2_TX_BREAK_EN
        txBreak = 1'b0;
`endif
        repeat (8) @(negedge ck)
            checkOutput("inhibitIdleHold", 32'({ps2c, ps2d, txReady}), 32'(3'b110));
        ps2cIn = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge ck);
            cnt++;
            if (txReady) seen = 1'b1;
        end
        checkOutput("inhibitReleaseAccept", 32'(seen && (cnt + 1 <= 3)), 32'(1));
        if (seen) begin
            expQ.push_back(modelFrame(8'h16));
            acc = cyc + 1;
            acceptEdge = acc;
            expectFirst = 1'b1;
        end
        @(negedge ck);
        txValid = 1'b0;
        waitReady(rc, ok2);
        if (ok2 && seen) checkOutput("inhibitIdleReadyReturn", 32'(rc - acc), 32'(FRAME_LEN + GP));

        // Abort during HI of b4, then a full retransmission from b0.
        applyStimulus(8'h16, 1'b0, 1'b1, acc, ok);
        while (cyc < acc + 8 * CD) @(negedge ck);
        checkOutput("b4Data", 32'({ps2c, ps2d}), 32'({1'b1, f16[4]}));
        ps2cIn = 1'b0;
        released = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ck);
            if (ps2c && ps2d) released = 1'b1;
        end
        checkOutput("abortLatency", 32'(released), 32'(1));
        repeat (6) @(negedge ck)
            checkOutput("abortHeld", 32'({ps2c, ps2d, txReady}), 32'(3'b110));
        ps2cIn = 1'b1;
        waitReady(rc, ok2);
        if (ok2) checkOutput("retransmitReady", 32'(rc - acc),
                             32'(8 * CD + 9 + 3 + GP + FRAME_LEN + GP));
        checkOutput("retransmitDelivered", 32'(expQ.size()), 32'(0));

        // Inhibit once b10 has started must not stop the frame.
        applyStimulus(8'h16, 1'b0, 1'b1, acc, ok);
        while (cyc < acc + 20 * CD + 1) @(negedge ck);
        ps2cIn = 1'b0;
        repeat (12) @(negedge ck);
        checkOutput("b10FrameComplete", 32'(expQ.size()), 32'(0));
        ps2cIn = 1'b1;
        waitReady(rc, ok2);

        // Reset in LO of b3 releases the lines without waiting for a clock edge.
        applyStimulus(8'h16, 1'b0, 1'b1, acc, ok);
        while (cyc < acc + 7 * CD + 1) @(negedge ck);
        checkOutput("lowBeforeReset", 32'(ps2c), 32'(0));
        #1 rst_n = 1'b0;
        #1 checkOutput("asyncResetLines", 32'({ps2c, ps2d}), 32'(2'b11));
        expQ.delete();
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        repeat (3) @(negedge ck);
        checkOutput("readyAfterMidReset", 32'(txReady), 32'(1));

`ifdef PS2_TX_BREAK_EN
        applyStimulus(8'h69, 1'b1, 1'b1, acc, ok);
        waitReady(rc, ok2);
        if (ok2) checkOutput("breakReadyReturn", 32'(rc - acc), 32'(2 * (FRAME_LEN + GP)));
        checkOutput("breakDelivered", 32'(expQ.size()), 32'(0));
`endif

        for (int it = 0; it < 24; it++) begin
            logic [7:0] d;
            bit brk;
            bit inh;
            d = 8'($urandom_range(0, 255));
            brk = 1'b0;
`ifdef PS2_TX_BREAK_EN
            brk = ($urandom_range(0, 3) == 0);
`endif
            inh = ($urandom_range(0, 2) == 0);
            applyStimulus(d, brk, !inh, acc, ok);
            if (inh) begin
                repeat ($urandom_range(0, 100)) @(negedge ck);
                ps2cIn = 1'b0;
                repeat ($urandom_range(1, 8)) @(negedge ck);
                ps2cIn = 1'b1;
            end
            waitReady(rc, ok2);
            if (ok && ok2 && !inh && !brk)
                checkOutput("randReadyReturn", 32'(rc - acc), 32'(FRAME_LEN + GP));
            repeat ($urandom_range(0, 3)) @(negedge ck);
        end

        for (int i = 0; i < 1000 && expQ.size() != 0; i++) @(negedge ck);
        checkOutput("finalDrained", 32'(expQ.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
